dmac_main_controller: RTL

- Control FSM that sequences the DMAC main datapath.
- Arbitrates the two peripheral request lines and latches the grant and peripheral base.
- Fetches the four configuration words (SAddr, DAddr, Size, Ctrl) from the peripheral config window over the AHB master port.
- Validates Ctrl, enables the matching channel until its completion interrupt, then returns to idle.

---
 rtl/dmac_main_controller_if.sv | 37 +++
 rtl/dmac_main_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmac_main_controller_if.sv
// ---------------------------------------------------------------------------
// dmac_main_controller_if
//   AHB-side signals used by the DMAC main controller while it fetches the
//   four configuration words from the peripheral config window.
//
//   HReady        : AHB ready, driven by the bus (slave side)
//   M_HResp       : AHB response, 00 = OKAY, anything else = error
//   config_HTrans : HTRANS issued during the fetch (00 IDLE, 10 NONSEQ)
//   config_write  : HWRITE during the fetch, always 0
//   addr_inc_sel  : config word offset select (00=A0, 01=A4, 10=A8, 11=AC)
//
//   master : the controller view (drives transfer controls)
//   slave  : the bus / testbench view (drives ready and response)
// ---------------------------------------------------------------------------
interface dmac_main_controller_if;
  logic       HReady;
  logic [1:0] M_HResp;
  logic [1:0] config_HTrans;
  logic       config_write;
  logic [1:0] addr_inc_sel;

  modport master (
    input  HReady,
    input  M_HResp,
    output config_HTrans,
    output config_write,
    output addr_inc_sel
  );

  modport slave (
    output HReady,
    output M_HResp,
    input  config_HTrans,
    input  config_write,
    input  addr_inc_sel
  );
endinterface

// File: rtl/dmac_main_controller.sv
// ---------------------------------------------------------------------------
// dmac_main_controller
//   Control FSM sequencing the DMAC main datapath. It arbitrates the two
//   peripheral request lines (peripheral 2 wins), fetches SAddr, DAddr, Size
//   and Ctrl from the granted peripheral's config window, validates the
//   config-valid bit, then enables the granted channel until its completion
//   interrupt arrives.
//
//   Parameters
//     ERR_ABORT : 1 = an AHB error response during the fetch aborts to IDLE
//                 with an err pulse; 0 = the word is captured regardless
//     CHK_CFG   : 1 = C_config low after the fetch is an error; 0 = no check
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     ahb                 : config-fetch AHB signals (master modport)
//     DmacReq[1:0]        : peripheral requests (bit1 = periph 2, bit0 = periph 1)
//     irq                 : channel transfer-complete
//     C_config            : config-valid bit from the captured Ctrl word
//     DmacReq_Reg_en      : latch DmacReq
//     PeriAddr_reg_en     : latch decoded peripheral base
//     SAddr/DAddr/Trans_sz/Ctrl_Reg_en : config register capture strobes
//     con_sel[1:0]        : master mux select (00 ch1, 01 ch2, 10 config)
//     con_en              : update the registered mux select
//     channel_en_1/2      : channel enables
//     busy                : high whenever the FSM is not idle
//     err                 : one-cycle error pulse
// ---------------------------------------------------------------------------
module dmac_main_controller #(
  parameter bit ERR_ABORT = 1'b1,
  parameter bit CHK_CFG   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  dmac_main_controller_if.master        ahb,
  input  logic [1:0]                    DmacReq,
  input  logic                          irq,
  input  logic                          C_config,
  output logic                          DmacReq_Reg_en,
  output logic                          PeriAddr_reg_en,
  output logic                          SAddr_Reg_en,
  output logic                          DAddr_Reg_en,
  output logic                          Trans_sz_Reg_en,
  output logic                          Ctrl_Reg_en,
  output logic [1:0]                    con_sel,
  output logic                          con_en,
  output logic                          channel_en_1,
  output logic                          channel_en_2,
  output logic                          busy,
  output logic                          err
);

  typedef enum logic [2:0] {
    IDLE, LATCH, ADDR, DATA, CHECK, XFER, DONE, ERR
  } state_e;

  localparam logic [1:0] SEL_CONFIG = 2'b10;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] wordCnt_q, wordCnt_d;
  logic       grant_q, grant_d;

  logic respErr;
  logic dataAccept;
  logic dataAbort;
  logic cfgOk;

  // Data-phase qualifiers. With ERR_ABORT cleared an error response is
  // treated exactly like OKAY, so the word is still captured.
  assign respErr    = (ahb.M_HResp != 2'b00);
  assign dataAccept = ahb.HReady && (!respErr || !ERR_ABORT);
  assign dataAbort  = ahb.HReady && respErr && ERR_ABORT;
  assign cfgOk      = !CHK_CFG || C_config;

  // State register, word counter and latched grant (0 = ch1, 1 = ch2).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wordCnt_q <= 2'd0;
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state logic. The grant is only captured on the IDLE->LATCH move,
  // so request changes during a fetch or transfer have no effect.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    grant_d   = grant_q;
    unique case (state_q)
      IDLE: begin
        if (DmacReq != 2'b00) begin
          state_d = LATCH;
          grant_d = DmacReq[1];
        end
      end
      LATCH: begin
        wordCnt_d = 2'd0;
        state_d   = ADDR;
      end
      ADDR: begin
        if (ahb.HReady) state_d = DATA;
      end
      DATA: begin
        if (dataAbort) begin
          state_d = ERR;
        end else if (dataAccept) begin
          if (wordCnt_q == 2'd3) begin
            state_d = CHECK;
          end else begin
            wordCnt_d = wordCnt_q + 2'd1;
            state_d   = ADDR;
          end
        end
      end
      CHECK: state_d = cfgOk ? XFER : ERR;
      XFER: begin
        if (irq) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Mostly Moore; the capture strobes in DATA and the
  // mux update in CHECK also depend on the current bus/config inputs.
  always_comb begin
    DmacReq_Reg_en    = 1'b0;
    PeriAddr_reg_en   = 1'b0;
    SAddr_Reg_en      = 1'b0;
    DAddr_Reg_en      = 1'b0;
    Trans_sz_Reg_en   = 1'b0;
    Ctrl_Reg_en       = 1'b0;
    con_sel           = SEL_CONFIG;
    con_en            = 1'b0;
    channel_en_1      = 1'b0;
    channel_en_2      = 1'b0;
    busy              = (state_q != IDLE);
    err               = 1'b0;
    ahb.config_HTrans = HTRANS_IDLE;
    ahb.config_write  = 1'b0;
    ahb.addr_inc_sel  = 2'b00;
    unique case (state_q)
      IDLE: ;
      LATCH: begin
        DmacReq_Reg_en  = 1'b1;
        PeriAddr_reg_en = 1'b1;
        con_en          = 1'b1;
      end
      ADDR: begin
        ahb.config_HTrans = HTRANS_NONSEQ;
        ahb.addr_inc_sel  = wordCnt_q;
        con_en            = 1'b1;
      end
      DATA: begin
        ahb.addr_inc_sel = wordCnt_q;
        if (dataAccept) begin
          unique case (wordCnt_q)
            2'd0: SAddr_Reg_en    = 1'b1;
            2'd1: DAddr_Reg_en    = 1'b1;
            2'd2: Trans_sz_Reg_en = 1'b1;
            2'd3: Ctrl_Reg_en     = 1'b1;
            default: ;
          endcase
        end
      end
      CHECK: begin
        if (cfgOk) begin
          con_sel = {1'b0, grant_q};
          con_en  = 1'b1;
        end
      end
      XFER: begin
        con_sel      = {1'b0, grant_q};
        channel_en_1 = !grant_q;
        channel_en_2 = grant_q;
      end
      DONE: con_en = 1'b1;
      ERR: begin
        err    = 1'b1;
        con_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
